// File: rtl/text_pkg.sv
// Shared constants and FSM encoding for the text-RAM character writer.
package text_pkg;

  localparam logic [7:0] CHAR_NL    = 8'h0A;
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead synchronous FIFO; dout always presents the head entry.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign dout  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/text_writer.sv
// Character-stream front end: FIFO, cursor tracking, control-char decode and
// text-RAM write sequencing gated by the display's write window.
module text_writer
  import text_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_write_ok,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_din,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] cursor;
  logic              advance;

  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [COL_W-1:0]  adv_col, bs_col;
  logic [ROW_W-1:0]  adv_row, bs_row, nl_row;
  logic [ADDR_W-1:0] adv_cursor, bs_cursor, nl_cursor;

  assign push     = i_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign o_ready  = !full;
  assign o_cursor = cursor;
  // The strobe is qualified by the live window so no write slips out while it is shut.
  assign o_we     = i_write_ok && ((state == WRITE) || (state == CLEAR));

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (i_data),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Cursor successors; the linear address is updated by +/-1 or a row stride.
  always_comb begin
    adv_col    = col + COL_W'(1);
    adv_row    = row;
    adv_cursor = cursor + ADDR_W'(1);
    if (col == LAST_COL) begin
      adv_col = COL_W'(0);
      if (row == LAST_ROW) begin
        adv_row    = ROW_W'(0);
        adv_cursor = ADDR_W'(0);
      end else begin
        adv_row = row + ROW_W'(1);
      end
    end else begin
      adv_col = col + COL_W'(1);
    end

    bs_col    = col;
    bs_row    = row;
    bs_cursor = cursor;
    if (col != COL_W'(0)) begin
      bs_col    = col - COL_W'(1);
      bs_cursor = cursor - ADDR_W'(1);
    end else if (row != ROW_W'(0)) begin
      bs_col    = LAST_COL;
      bs_row    = row - ROW_W'(1);
      bs_cursor = cursor - ADDR_W'(1);
    end else begin
      bs_cursor = ADDR_W'(0);
    end

    nl_row    = (row == LAST_ROW) ? ROW_W'(0) : row + ROW_W'(1);
    nl_cursor = (row == LAST_ROW) ? ADDR_W'(0)
                                  : cursor - ADDR_W'(col) + ADDR_W'(COLS);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      col        <= COL_W'(0);
      row        <= ROW_W'(0);
      cursor     <= ADDR_W'(0);
      advance    <= 1'b0;
      o_addr     <= ADDR_W'(0);
      o_din      <= DATA_W'(0);
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (i_valid && full) o_overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head == DATA_W'(CHAR_NL)) begin
              col    <= COL_W'(0);
              row    <= nl_row;
              cursor <= nl_cursor;
            end else if (head == DATA_W'(CHAR_BS)) begin
              col     <= bs_col;
              row     <= bs_row;
              cursor  <= bs_cursor;
              o_addr  <= bs_cursor;
              o_din   <= DATA_W'(CHAR_SPACE);
              advance <= 1'b0;
              state   <= WRITE;
            end else if (head == DATA_W'(CHAR_FF)) begin
              o_addr <= ADDR_W'(0);
              o_din  <= DATA_W'(CHAR_SPACE);
              o_busy <= 1'b1;
              state  <= CLEAR;
            end else begin
              o_addr  <= cursor;
              o_din   <= head;
              advance <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          if (i_write_ok) begin
            if (advance) begin
              col    <= adv_col;
              row    <= adv_row;
              cursor <= adv_cursor;
            end
            state <= IDLE;
          end
        end
        CLEAR: begin
          if (i_write_ok) begin
            if (o_addr == LAST_CELL) begin
              col    <= COL_W'(0);
              row    <= ROW_W'(0);
              cursor <= ADDR_W'(0);
              o_busy <= 1'b0;
              state  <= IDLE;
            end else begin
              o_addr <= o_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer.
module tb_text_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        o_ready;
  logic        i_write_ok = 1'b1;
  logic [11:0] o_addr;
  logic [7:0]  o_din;
  logic        o_we;
  logic [11:0] o_cursor;
  logic        o_busy;
  logic        o_overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic        wr_busy_q [$];
  int          we_blocked = 0;
  logic        saw_2400 = 1'b0;

  text_writer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .i_write_ok (i_write_ok),
    .o_addr     (o_addr),
    .o_din      (o_din),
    .o_we       (o_we),
    .o_cursor   (o_cursor),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Write logger: inputs change just after posedge, so mid-cycle is stable.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_we) begin
        wr_addr_q.push_back(o_addr);
        wr_data_q.push_back(o_din);
        wr_busy_q.push_back(o_busy);
        if (!i_write_ok) we_blocked++;
      end
      if (o_addr == 12'd2400) saw_2400 = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    i_valid = 1'b1;
    i_data  = c;
    step();
    i_valid = 1'b0;
    repeat (4) step();
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_busy_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},       32'(o_we),       32'd0);
    check({tag, "_addr"},     32'(o_addr),     32'd0);
    check({tag, "_din"},      32'(o_din),      32'd0);
    check({tag, "_cursor"},   32'(o_cursor),   32'd0);
    check({tag, "_busy"},     32'(o_busy),     32'd0);
    check({tag, "_overflow"}, 32'(o_overflow), 32'd0);
    check({tag, "_ready"},    32'(o_ready),    32'd1);
  endtask

  initial begin
    int cycles;
    int bad;
    int busy_bad;
    int accepted;
    int n_before;

    // Reset state
    repeat (3) step();
    check_reset_values("rst");
    i_rst = 1'b0;
    step();

    // Latency: char accepted in cycle N strobes o_we in cycle N+2
    i_valid = 1'b1;
    i_data  = 8'h41;
    step();
    i_valid = 1'b0;
    @(negedge i_clk);
    check("lat_we_n1", 32'(o_we), 32'd0);
    step();
    @(negedge i_clk);
    check("lat_we_n2", 32'(o_we), 32'd1);
    check("lat_addr", 32'(o_addr), 32'd0);
    check("lat_din", 32'(o_din), 32'h41);
    step();
    @(negedge i_clk);
    check("lat_we_n3", 32'(o_we), 32'd0);
    check("lat_cursor", 32'(o_cursor), 32'd1);

    // Backspace at cursor 0 saturates and blanks cell 0
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    step();
    clear_log();
    send_char(8'h08);
    check("bs_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("bs_addr", 32'(wr_addr_q[0]), 32'd0);
      check("bs_data", 32'(wr_data_q[0]), 32'h20);
    end
    check("bs_cursor", 32'(o_cursor), 32'd0);

    // Newline from cursor 85 lands on 160 without writing
    send_char(8'h0A);
    for (int k = 0; k < 5; k++) send_char(8'h61 + 8'(k));
    check("pre_nl_cursor", 32'(o_cursor), 32'd85);
    n_before = wr_addr_q.size();
    send_char(8'h0A);
    check("nl_cursor", 32'(o_cursor), 32'd160);
    check("nl_no_write", 32'(wr_addr_q.size()), 32'(n_before));

    // Walk to the last cell (row 29, col 79) and wrap
    for (int k = 0; k < 27; k++) send_char(8'h0A);
    check("row29_cursor", 32'(o_cursor), 32'd2320);
    for (int k = 0; k < 79; k++) send_char(8'h2E);
    check("last_cursor", 32'(o_cursor), 32'd2399);
    clear_log();
    send_char(8'h42);
    check("wrap_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("wrap_addr", 32'(wr_addr_q[0]), 32'd2399);
      check("wrap_data", 32'(wr_data_q[0]), 32'h42);
    end
    check("wrap_cursor", 32'(o_cursor), 32'd0);
    check("never_2400", 32'(saw_2400), 32'd0);

    // Writes deferred while the window is closed, then issued in order
    clear_log();
    i_write_ok = 1'b0;
    send_char(8'h41);
    send_char(8'h42);
    repeat (5) step();
    check("blocked_count", 32'(wr_addr_q.size()), 32'd0);
    i_write_ok = 1'b1;
    repeat (8) step();
    check("deferred_count", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("deferred0_addr", 32'(wr_addr_q[0]), 32'd0);
      check("deferred0_data", 32'(wr_data_q[0]), 32'h41);
      check("deferred1_addr", 32'(wr_addr_q[1]), 32'd1);
      check("deferred1_data", 32'(wr_data_q[1]), 32'h42);
    end
    check("deferred_cursor", 32'(o_cursor), 32'd2);

    // Full-screen clear with a 50% duty write window
    clear_log();
    i_valid = 1'b1;
    i_data  = 8'h0C;
    step();
    i_valid = 1'b0;
    step();
    @(negedge i_clk);
    check("clr_busy_start", 32'(o_busy), 32'd1);
    cycles = 0;
    while (o_busy && cycles < 10000) begin
      i_write_ok = ~i_write_ok;
      step();
      cycles++;
    end
    i_write_ok = 1'b1;
    check("clr_in_time", 32'(cycles < 10000), 32'd1);
    check("clr_count", 32'(wr_addr_q.size()), 32'd2400);
    bad = 0;
    busy_bad = 0;
    for (int k = 0; k < wr_addr_q.size(); k++) begin
      if (wr_addr_q[k] !== 12'(k) || wr_data_q[k] !== 8'h20) bad++;
      if (wr_busy_q[k] !== 1'b1) busy_bad++;
    end
    check("clr_content_bad", 32'(bad), 32'd0);
    check("clr_busy_bad", 32'(busy_bad), 32'd0);
    @(negedge i_clk);
    check("clr_cursor", 32'(o_cursor), 32'd0);
    check("clr_busy_end", 32'(o_busy), 32'd0);
    check("we_while_blocked", 32'(we_blocked), 32'd0);

    // Overflow during a paused clear, then asynchronous reset mid-clear
    i_valid = 1'b1;
    i_data  = 8'h0C;
    step();
    i_valid = 1'b0;
    repeat (11) step();
    i_write_ok = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_data  = 8'h61 + 8'(k);
      @(negedge i_clk);
      if (o_ready) accepted++;
      step();
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    check("ovf_accepted", 32'(accepted), 32'd4);
    check("ovf_ready", 32'(o_ready), 32'd0);
    check("ovf_flag", 32'(o_overflow), 32'd1);
    check("ovf_busy", 32'(o_busy), 32'd1);
    i_write_ok = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_values("midclr");
    step();
    i_rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Parametrised character-stream front end for the VGA text RAM: accepts characters, buffers them in a small FIFO, and turns them into text-RAM writes.
- Keeps a row/column cursor. Interprets newline, backspace and form-feed (full-screen clear).
- Issues RAM writes only while the display pipeline grants a write window.
- Sits between the debounced input logic and the vga block's i_addr/i_din/i_we write port.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- DATA_W, 8, character code width
- ADDR_W, 12, text-RAM address width; must satisfy 2**ADDR_W >= COLS*ROWS
- FIFO_DEPTH, 4, input FIFO entries, power of two >= 2

Ports:
- i_clk  in  1  system pixel clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  character strobe, one char per high cycle
- i_data  in  DATA_W  character code
- o_ready  out  1  FIFO not full; a char is accepted when i_valid && o_ready
- i_write_ok  in  1  RAM write window open (e.g. ~hsync); no write issued while low
- o_addr  out  ADDR_W  text-RAM write address
- o_din  out  DATA_W  text-RAM write data
- o_we  out  1  one-cycle write strobe
- o_cursor  out  ADDR_W  current cursor address, row*COLS+col
- o_busy  out  1  clear sequence in progress
- o_overflow  out  1  sticky: a char was offered while o_ready low

Behaviour:
- Reset (async, any cycle, including mid-clear):
  - o_we=0, o_addr=0, o_din=0, o_cursor=0, o_busy=0, o_overflow=0, o_ready=1.
  - FIFO emptied; state IDLE.
- FIFO:
  - Push on i_valid&&o_ready; o_ready = !full.
  - Push and pop in the same cycle are legal when the FIFO is neither empty nor full.
  - i_valid while full: char dropped, o_overflow set until reset.
- Cursor:
  - Held as separate row/col counters plus an incrementally maintained linear address; no multiplier.
  - Linear range 0..COLS*ROWS-1. The value COLS*ROWS is never produced.
- States:
  - IDLE: if FIFO non-empty, pop the head and decode it:
    - Printable (not NL/BS/FF) -> WRITE, with o_din=char, o_addr=cursor.
    - 0x0A NL -> col=0, row+1 (ROWS-1 wraps to 0); no write; stays IDLE.
    - 0x08 BS -> cursor-1 (saturates at 0, no wrap) -> WRITE, with o_din=0x20 at the new cursor.
    - 0x0C FF -> CLEAR, with o_addr=0, o_din=0x20, o_busy=1.
  - WRITE: hold o_addr/o_din stable until i_write_ok is high, then assert o_we for exactly one cycle.
    - For a printable char, advance the cursor in that same cycle: col+1; at COLS-1, col=0, row+1; at the last cell, wrap to 0.
    - Return to IDLE.
  - CLEAR: o_we=1 in every cycle with i_write_ok high; o_addr increments after each write.
    - Pauses with o_we=0 while i_write_ok is low.
    - After the write to COLS*ROWS-1: cursor=0, o_busy=0, return to IDLE.
    - FIFO keeps accepting input during CLEAR.
- Latency: when the FIFO is empty, the state is IDLE and i_write_ok is high, a char accepted in cycle N produces o_we in cycle N+2.
- Every o_we is a single-cycle pulse.
- o_addr/o_din are stable whenever o_we=1.
- No write is ever issued while i_write_ok=0.
- Writes are not lost when i_write_ok drops; they are deferred.

Decomposition:
- Package text_pkg holds:
  - CHAR_NL=8'h0A, CHAR_BS=8'h08, CHAR_FF=8'h0C, CHAR_SPACE=8'h20
  - state encoding IDLE/WRITE/CLEAR
- One sub-module: sync_fifo, parametrised by DATA_W and FIFO_DEPTH.
  - Ports: clk, async-high reset, push, pop, din, dout, full, empty.
- Cursor, decode and FSM logic stay in text_writer.

Test Plan:
- Reset, then "A"(0x41) with i_write_ok=1 -> o_we in cycle N+2 with o_addr=0, o_din=0x41; o_cursor=1 afterwards.
- Cursor at 2399 (row 29, col 79), send 0x42 -> write at addr 2399, then o_cursor=0; o_addr never equals 2400.
- Cursor at 85, send NL -> o_cursor=160 with no o_we. Cursor at 0, send BS -> write 0x20 at addr 0, o_cursor stays 0.
- Hold i_write_ok=0, send 0x41, 0x42 -> no o_we. Raise i_write_ok -> two pulses: addr 0/0x41, then addr 1/0x42, in order.
- Send FF, toggle i_write_ok 50% duty -> exactly 2400 o_we pulses, addr 0..2399 each once with data 0x20, o_busy high throughout. Then o_cursor=0, o_busy=0.
- With i_write_ok=0, offer 6 chars to a depth-4 FIFO -> 4 accepted, o_ready low, o_overflow=1. Assert i_rst mid-CLEAR -> all outputs return to their reset values immediately.
